// File: rtl/spart_pkg.sv
// Shared SPART types and constants for the transmitter and receiver.
// Frame layout is 8N1: start(0), eight data bits LSB-first, stop(1).
package spart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        TX   = 1'b1
    } tx_state_t;

    localparam logic [1:0] SPART_DATA_ADDR = 2'b00;
    localparam int         FRAME_BITS      = 10;

    // The frame shifts out from bit 0, so the start bit sits at the bottom.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/spart_bit_timer.sv
// OVERSAMPLE-modulo counter of baud enable ticks; bit_done pulses on the last tick of a bit.
// Zero latency (bit_done is combinational from enable); counter freezes while enable is low.
module spart_bit_timer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic enable,
    output logic bit_done
);

    localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    logic [TW-1:0] tick_cnt;

    assign bit_done = enable && !clr && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (clr) begin
            tick_cnt <= '0;
        end else if (enable) begin
            if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end
        end
    end

endmodule

// File: rtl/spart_tx.sv
// SPART transmitter: bus writes into a one-byte holding register, serialized as 8N1 on txd.
// Start bit 1 clk after an idle write; writes while tbr=0 are dropped, back-to-back frames have no gap.
module spart_tx
    import spart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       tbr
);

    tx_state_t             state;
    logic [FRAME_BITS-1:0] shreg;
    logic [3:0]            bit_cnt;
    logic [7:0]            hold;
    logic                  hold_valid;
    logic                  wr;
    logic                  accept;
    logic                  bit_done;

    assign wr     = iocs && !iorw && (ioaddr == SPART_DATA_ADDR);
    assign accept = wr && tbr;
    assign txd    = shreg[0];

    // The timer only runs while a frame is on the line; IDLE holds it at zero
    // so the first bit of a new frame always gets a full OVERSAMPLE ticks.
    spart_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state == IDLE),
        .enable   (enable),
        .bit_done (bit_done)
    );

    // tbr tracks !hold_valid exactly, so an accepted write (tbr=1) can never
    // coincide with a holding->shift transfer (hold_valid=1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '1;
            bit_cnt    <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
            tbr        <= 1'b1;
        end else begin
            if (accept) begin
                hold       <= tx_data;
                hold_valid <= 1'b1;
                tbr        <= 1'b0;
            end

            case (state)
                IDLE: begin
                    shreg <= '1;
                    if (hold_valid) begin
                        shreg      <= make_frame(hold);
                        bit_cnt    <= '0;
                        hold_valid <= 1'b0;
                        tbr        <= 1'b1;
                        state      <= TX;
                    end
                end
                TX: begin
                    if (bit_done) begin
                        if (bit_cnt < 4'(FRAME_BITS - 1)) begin
                            shreg   <= {1'b1, shreg[FRAME_BITS-1:1]};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (hold_valid) begin
                            // Stop bit ends on the same edge the next start bit begins.
                            shreg      <= make_frame(hold);
                            bit_cnt    <= '0;
                            hold_valid <= 1'b0;
                            tbr        <= 1'b1;
                        end else begin
                            shreg <= '1;
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spart_tx.sv
// Directed bench for spart_tx: frame shape, bit timing, holding register, reset abort and decode.
module tb_spart_tx;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] tx_data;
    logic       txd;
    logic       tbr;

    int checks      = 0;
    int failures    = 0;
    int en_mode     = 0;   // 0: enable low, 1: enable high, 2: every 4th clk
    int cnt         = 0;
    int stall_left  = 0;

    spart_tx #(.OVERSAMPLE(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .tx_data (tx_data),
        .txd     (txd),
        .tbr     (tbr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and set enable for the following rising edge.
    task automatic step();
        @(negedge clk);
        if (stall_left > 0) begin
            stall_left--;
            enable = 1'b0;
        end else begin
            cnt++;
            enable = (en_mode == 2) ? (cnt % 4 == 0) : (en_mode == 1);
        end
    endtask

    task automatic bus_op(input logic cs, input logic rw, input logic [1:0] addr, input logic [7:0] d);
        iocs    = cs;
        iorw    = rw;
        ioaddr  = addr;
        tx_data = d;
        step();
        iocs    = 1'b0;
        iorw    = 1'b1;
        ioaddr  = 2'b00;
        tx_data = 8'h00;
    endtask

    task automatic idle_check(input string tag, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (txd !== 1'b1 || tbr !== 1'b1) bad++;
        end
        chk(tag, bad, 0);
    endtask

    // Current falling edge is sample s0 of the start bit; checks every sample of the frame.
    task automatic check_frame(input string tag, input logic [7:0] d, input int b_clks,
                               input int s0, input int stall_bit, input int stall_at);
        int   bad;
        int   len;
        logic exp_b;
        bit   first;
        first = 1'b1;
        for (int b = 0; b < 10; b++) begin
            len   = b_clks + ((b == stall_bit) ? 100 : 0);
            exp_b = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1];
            bad   = 0;
            for (int k = 0; k < len; k++) begin
                if (b == 0 && k < s0) continue;
                if (!first) step();
                first = 1'b0;
                if (txd !== exp_b) bad++;
                if (b == stall_bit && k == stall_at) stall_left = 100;
            end
            chk($sformatf("%s_bit%0d", tag, b), bad, 0);
        end
    endtask

    initial begin
        rst_n   = 1'b1;
        enable  = 1'b0;
        iocs    = 1'b0;
        iorw    = 1'b1;
        ioaddr  = 2'b00;
        tx_data = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_txd", txd, 1'b1);
        chk("reset_tbr", tbr, 1'b1);
        step(); step(); step();
        rst_n = 1'b1;

        // Idle with reads of the data register.
        iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00; tx_data = 8'hC3;
        idle_check("idle_reads", 50);
        iocs = 1'b0;

        // A5 with enable tied high.
        en_mode = 1;
        step();
        bus_op(1'b1, 1'b0, 2'b00, 8'hA5);
        chk("a5_tbr_after_wr", tbr, 1'b0);
        chk("a5_txd_after_wr", txd, 1'b1);
        step();
        chk("a5_tbr_after_load", tbr, 1'b1);
        check_frame("a5", 8'hA5, 16, 0, -1, 0);
        idle_check("a5_idle_after", 20);

        // 55 then 0F back to back; FF written while full is dropped.
        bus_op(1'b1, 1'b0, 2'b00, 8'h55);
        step();
        chk("b2b_start55", txd, 1'b0);
        bus_op(1'b1, 1'b0, 2'b00, 8'h0F);
        chk("b2b_tbr_full", tbr, 1'b0);
        bus_op(1'b1, 1'b0, 2'b00, 8'hFF);
        chk("b2b_tbr_after_drop", tbr, 1'b0);
        check_frame("f55", 8'h55, 16, 2, -1, 0);
        step();
        chk("b2b_tbr_reload", tbr, 1'b1);
        check_frame("f0f", 8'h0F, 16, 0, -1, 0);
        idle_check("b2b_idle_after", 40);

        // enable every 4th clk, 01 with a 100-clk stall in the middle of data bit 1.
        en_mode = 2;
        cnt     = 3;
        enable  = 1'b0;
        bus_op(1'b1, 1'b0, 2'b00, 8'h01);
        step();
        chk("div4_start", txd, 1'b0);
        check_frame("f01", 8'h01, 64, 0, 2, 30);
        idle_check("div4_idle_after", 80);

        // Reset during data bit 3 of 3C with a byte pending in the holding register.
        en_mode = 1;
        bus_op(1'b1, 1'b0, 2'b00, 8'h3C);
        step();
        chk("rst_start", txd, 1'b0);
        bus_op(1'b1, 1'b0, 2'b00, 8'h00);
        chk("rst_tbr_full", tbr, 1'b0);
        for (int i = 1; i < 20; i++) step();
        chk("rst_d0", txd, 1'b0);
        for (int i = 20; i < 70; i++) step();
        chk("rst_d3", txd, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_txd", txd, 1'b1);
        chk("rst_async_tbr", tbr, 1'b1);
        step(); step();
        rst_n = 1'b1;
        idle_check("rst_idle_after", 60);

        // Writes to another address or with iorw=1 are ignored.
        bus_op(1'b1, 1'b0, 2'b01, 8'h00);
        chk("bad_addr_tbr", tbr, 1'b1);
        idle_check("bad_addr_idle", 30);
        bus_op(1'b1, 1'b1, 2'b00, 8'h00);
        chk("read_tbr", tbr, 1'b1);
        idle_check("read_idle", 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
